prach_fft_framer: RTL and testbench



---
 rtl/prach_fft_framer.sv | 100 ++++++++++
 tb/tb_prach_fft_framer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/prach_fft_framer.sv
// prach_fft_framer: buffers a gappy I/Q stream in a FIFO and emits contiguous
// NUM_FFT_LENGTH-sample bursts framed by sync_ahead_out / sync_out for the FFT.
module prach_fft_framer #(
   parameter int NUM_FFT_LENGTH = 6,
   parameter int NUM_SYNC_AHEAD = 2,
   parameter int FIFO_DEPTH     = 2*NUM_FFT_LENGTH
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [17:0] din_dr,
   input  logic [17:0] din_di,
   input  logic        din_dv,
   output logic [17:0] dout_dr,
   output logic [17:0] dout_di,
   output logic        dout_dv,
   output logic        sync_out,
   output logic        sync_ahead_out,
   output logic        overflow,
   output logic [15:0] frame_cnt
);
   localparam int N  = NUM_FFT_LENGTH;
   localparam int A  = NUM_SYNC_AHEAD;
   localparam int D  = FIFO_DEPTH;
   localparam int AW = $clog2(D);
   localparam int CW = $clog2(D+1);
   localparam int IW = $clog2(N);
   localparam int LW = (A > 1) ? $clog2(A) : 1;
   localparam logic [IW-1:0] IDX_LAST  = IW'(N-1);
   localparam logic [IW-1:0] IDX_AHEAD = IW'(N-A-1);

   typedef enum logic [1:0] {IDLE, LEAD, BURST} state_t;

   state_t            state, state_nx;
   logic [35:0]       mem [D];
   logic [AW-1:0]     wptr, rptr;
   logic [CW-1:0]     count, owed;
   logic [CW:0]       avail;
   logic [IW-1:0]     idx;
   logic [LW-1:0]     lead;
   logic              reserved, push, wr, pop, start, avail_ok, reserve;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   always_comb begin
      state_nx = (state == IDLE) ? (reserve ? LEAD : IDLE)
               : (state == LEAD) ? ((lead == '0) ? BURST : LEAD)
               : (idx == IDX_LAST && !reserved) ? IDLE : BURST;
   end

   // Decisions are taken on the edge before the cycle they show up in, so every
   // output can be a plain register; owed tracks reserved-but-unread samples.
   always_comb begin
      push     = din_dv & enable;
      pop      = (state == LEAD && lead == '0) || (state == BURST && (idx != IDX_LAST || reserved));
      start    = pop && (state == LEAD || idx == IDX_LAST);
      wr       = push && (count != CW'(D) || pop);
      avail    = {1'b0, count} + (CW+1)'(wr) - {1'b0, owed};
      avail_ok = avail >= (CW+1)'(N);
      reserve  = avail_ok && (state == IDLE || (state == BURST && idx == IDX_AHEAD));
   end

   always_ff @(posedge clk)
      if (wr) mem[wptr] <= {din_di, din_dr};

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wptr           <= '0;
         rptr           <= '0;
         count          <= '0;
         owed           <= '0;
         idx            <= '0;
         lead           <= '0;
         reserved       <= 1'b0;
         dout_dr        <= '0;
         dout_di        <= '0;
         dout_dv        <= 1'b0;
         sync_out       <= 1'b0;
         sync_ahead_out <= 1'b0;
         overflow       <= 1'b0;
         frame_cnt      <= '0;
      end else begin
         wptr           <= wr ? ((wptr == AW'(D-1)) ? '0 : wptr + AW'(1)) : wptr;
         rptr           <= pop ? ((rptr == AW'(D-1)) ? '0 : rptr + AW'(1)) : rptr;
         count          <= count + CW'(wr) - CW'(pop);
         owed           <= owed + (reserve ? CW'(N) : '0) - CW'(pop);
         idx            <= start ? '0 : (state == BURST) ? idx + IW'(1) : idx;
         lead           <= (state == IDLE) ? LW'(A-1) : (lead != '0) ? lead - LW'(1) : lead;
         reserved       <= start ? 1'b0 : (reserve && state == BURST) ? 1'b1 : reserved;
         dout_dr        <= pop ? mem[rptr][17:0] : '0;
         dout_di        <= pop ? mem[rptr][35:18] : '0;
         dout_dv        <= pop;
         sync_out       <= start;
         sync_ahead_out <= reserve;
         overflow       <= push & ~wr;
         frame_cnt      <= frame_cnt + 16'(start);
      end
endmodule

// File: tb/tb_prach_fft_framer.sv
// tb_prach_fft_framer: directed framing scenarios with hand-computed cycle numbers.
module tb_prach_fft_framer;
   logic        clk = 0, rst = 0, enable = 0, din_dv = 0;
   logic [17:0] din_dr = 0, din_di = 0;
   logic [17:0] a_dr, a_di, b_dr, b_di;
   logic        a_dv, a_so, a_sa, a_ov, b_dv, b_so, b_sa, b_ov;
   logic [15:0] a_fc, b_fc;

   always #5 clk = ~clk;

   prach_fft_framer u_a (
      .clk(clk), .rst(rst), .enable(enable), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
      .dout_dr(a_dr), .dout_di(a_di), .dout_dv(a_dv), .sync_out(a_so), .sync_ahead_out(a_sa),
      .overflow(a_ov), .frame_cnt(a_fc));

   prach_fft_framer #(.FIFO_DEPTH(6)) u_b (
      .clk(clk), .rst(rst), .enable(enable), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
      .dout_dr(b_dr), .dout_di(b_di), .dout_dv(b_dv), .sync_out(b_so), .sync_ahead_out(b_sa),
      .overflow(b_ov), .frame_cnt(b_fc));

   int n_cmp = 0, n_bad = 0, t = 0;
   bit sel = 0;
   int sa_q[$], so_q[$], dr_q[$], di_q[$];
   int dv_n, dv_first, dv_last, ovf_n, ovf_t, zero_bad;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   function automatic longint outs_a();
      return longint'({a_dr, a_di, a_dv, a_so, a_sa, a_ov, a_fc});
   endfunction

   task automatic clear();
      sa_q.delete(); so_q.delete(); dr_q.delete(); di_q.delete();
      dv_n = 0; dv_first = -1; dv_last = -1; ovf_n = 0; ovf_t = -1; zero_bad = 0; t = 0;
   endtask

   task automatic record();
      logic [17:0] dr = sel ? b_dr : a_dr;
      logic [17:0] di = sel ? b_di : a_di;
      logic dv = sel ? b_dv : a_dv;
      if (sel ? b_sa : a_sa) sa_q.push_back(t);
      if (sel ? b_so : a_so) so_q.push_back(t);
      if (sel ? b_ov : a_ov) begin ovf_n++; ovf_t = t; end
      if (dv) begin
         if (dv_n == 0) dv_first = t;
         dv_last = t;
         dv_n++;
         dr_q.push_back(int'($signed(dr)));
         di_q.push_back(int'($signed(di)));
      end else if (dr != 0 || di != 0) zero_bad++;
   endtask

   task automatic cyc(input logic en, input logic dv, input int v);
      enable = en; din_dv = dv; din_dr = 18'(v); din_di = 18'(-v);
      @(negedge clk);
      record();
      @(posedge clk);
      #1 t++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0);
   endtask

   task automatic do_reset();
      rst = 1; enable = 0; din_dv = 0; din_dr = 0; din_di = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      clear();
   endtask

   initial begin
      #2 rst = 1;
      #1 check("reset outs async", outs_a(), 0);
      @(posedge clk); #1 check("reset outs clocked", outs_a(), 0);
      check("reset fc b", longint'(b_fc), 0);

      // single frame, contiguous input
      sel = 0; do_reset();
      for (int k = 1; k <= 6; k++) cyc(1'b1, 1'b1, k);
      idle(14);
      check("t1 sa count", sa_q.size(), 1);
      check("t1 sa cycle", qat(sa_q, 0), 6);
      check("t1 so cycle", qat(so_q, 0), 8);
      check("t1 dv first", dv_first, 8);
      check("t1 dv count", dv_n, 6);
      for (int k = 0; k < 6; k++) check($sformatf("t1 dr%0d", k), qat(dr_q, k), k + 1);
      check("t1 di5", qat(di_q, 5), -6);
      check("t1 frame_cnt", longint'(a_fc), 1);
      check("t1 idle zeros", zero_bad, 0);

      // gappy input, one sample every other cycle
      do_reset();
      for (int c = 0; c < 12; c++) cyc(1'b1, c % 2 == 0, c / 2 + 1);
      idle(12);
      check("t2 sa cycle", qat(sa_q, 0), 11);
      check("t2 so cycle", qat(so_q, 0), 13);
      check("t2 dv span", dv_last - dv_first + 1, 6);
      check("t2 dv count", dv_n, 6);
      check("t2 dr5", qat(dr_q, 5), 6);

      // two back-to-back frames
      do_reset();
      for (int k = 1; k <= 12; k++) cyc(1'b1, 1'b1, k);
      idle(14);
      check("t3 sa count", sa_q.size(), 2);
      check("t3 sa2 cycle", qat(sa_q, 1), 12);
      check("t3 so1 cycle", qat(so_q, 0), 8);
      check("t3 so2 cycle", qat(so_q, 1), 14);
      check("t3 dv span", dv_last - dv_first + 1, 12);
      check("t3 dv count", dv_n, 12);
      check("t3 dr6", qat(dr_q, 6), 7);
      check("t3 dr11", qat(dr_q, 11), 12);
      check("t3 frame_cnt", longint'(a_fc), 2);

      // shallow FIFO: sample 7 arrives while full with no read, sample 8 rides a read
      sel = 1; do_reset();
      for (int k = 1; k <= 8; k++) cyc(1'b1, 1'b1, k);
      idle(14);
      check("t4 overflow count", ovf_n, 1);
      check("t4 overflow cycle", ovf_t, 7);
      check("t4 so count", so_q.size(), 1);
      check("t4 dv count", dv_n, 6);
      check("t4 dr0", qat(dr_q, 0), 1);
      check("t4 dr5", qat(dr_q, 5), 6);
      check("t4 frame_cnt", longint'(b_fc), 1);

      // reset in the middle of a burst
      sel = 0; do_reset();
      for (int k = 1; k <= 6; k++) cyc(1'b1, 1'b1, k);
      idle(5);
      check("t5 dv at idx3", longint'(a_dv), 1);
      check("t5 dr at idx3", longint'($signed(a_dr)), 4);
      rst = 1;
      #1 check("t5 outs in reset", outs_a(), 0);
      @(posedge clk);
      #1 rst = 0;
      clear();
      idle(20);
      check("t5 so after reset", so_q.size(), 0);
      check("t5 sa after reset", sa_q.size(), 0);
      check("t5 frame_cnt", longint'(a_fc), 0);

      // enable low drops samples 4..6; 7..9 complete the frame
      do_reset();
      for (int k = 1; k <= 6; k++) cyc(k <= 3, 1'b1, k);
      idle(4);
      check("t6 no early launch", sa_q.size(), 0);
      for (int k = 7; k <= 9; k++) cyc(1'b1, 1'b1, k);
      idle(12);
      check("t6 sa cycle", qat(sa_q, 0), 13);
      check("t6 so cycle", qat(so_q, 0), 15);
      check("t6 dv count", dv_n, 6);
      check("t6 dr2", qat(dr_q, 2), 3);
      check("t6 dr3", qat(dr_q, 3), 7);
      check("t6 dr5", qat(dr_q, 5), 9);
      check("t6 di3", qat(di_q, 3), -7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
